// File: rtl/board_ctrl.sv
// Front-panel control: synchronises and debounces btnL/btnR, then turns presses
// into a timed processor reset pulse (rst_out) and a run/stop enable (en_out).
module board_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
    parameter int unsigned CNT_W            = 20,
    parameter int unsigned RST_PULSE_CYCLES = 16,
    parameter logic        EN_INIT          = 1'b1
) (
    input  logic       clk0,
    input  logic       rst0,
    input  logic       btnL,
    input  logic       btnR,
    output logic       rst_out,
    output logic       en_out,
    output logic [1:0] btn_state
);

    localparam int unsigned NBTN   = 2;
    localparam int unsigned PCNT_W = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(RST_PULSE_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bit 0 is btnL, bit 1 is btnR throughout.
    logic [NBTN-1:0]  raw;
    logic [NBTN-1:0]  s1;
    logic [NBTN-1:0]  s2;
    logic [NBTN-1:0]  stable;
    logic [NBTN-1:0]  stable_nxt;
    logic [NBTN-1:0]  stable_q;
    logic [NBTN-1:0]  press;
    logic [CNT_W-1:0] db_cnt     [NBTN];
    logic [CNT_W-1:0] db_cnt_nxt [NBTN];

    state_t            state;
    state_t            state_nxt;
    logic [PCNT_W-1:0] pcnt;
    logic [PCNT_W-1:0] pcnt_nxt;
    logic              en_nxt;

    assign raw       = {btnR, btnL};
    assign btn_state = stable;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < NBTN; i++) begin
            db_cnt_nxt[i] = '0;
            if (s2[i] != stable[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    stable_nxt[i] = ~stable[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
            stable   <= '0;
            stable_q <= '0;
            press    <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= db_cnt_nxt[i];
            end
            stable   <= stable_nxt;
            stable_q <= stable;
            press    <= stable & ~stable_q;
        end
    end

    // btnL always wins; a btnR press only toggles enable while no pulse is running.
    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        en_nxt    = en_out;
        case (state)
            IDLE: begin
                if (press[0]) begin
                    state_nxt = HOLD;
                    pcnt_nxt  = '0;
                    en_nxt    = EN_INIT;
                end else if (press[1]) begin
                    en_nxt = ~en_out;
                end
            end
            HOLD: begin
                if (press[0]) begin
                    pcnt_nxt = '0;
                    en_nxt   = EN_INIT;
                end else if (pcnt == PULSE_LAST) begin
                    state_nxt = IDLE;
                    pcnt_nxt  = '0;
                end else begin
                    pcnt_nxt = pcnt + PCNT_W'(1);
                end
            end
            default: begin
                state_nxt = HOLD;
                pcnt_nxt  = '0;
            end
        endcase
    end

    // Reset lands in HOLD so the processor sees a full power-on pulse.
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            state   <= HOLD;
            pcnt    <= '0;
            en_out  <= EN_INIT;
            rst_out <= 1'b1;
        end else begin
            state   <= state_nxt;
            pcnt    <= pcnt_nxt;
            en_out  <= en_nxt;
            rst_out <= (state_nxt == HOLD);
        end
    end

endmodule

// File: tb/tb_board_ctrl.sv
// Bench for board_ctrl: directed vector table, hand-written corner sequences and
// randomised button activity, all compared against an edge-indexed reference model.
module tb_board_ctrl;

    localparam int   D       = 4;
    localparam int   P       = 3;
    localparam logic EN_INIT = 1'b1;
    localparam int   MAXE    = 16384;

    logic       clk0 = 1'b0;
    logic       rst0 = 1'b0;
    logic       btnL = 1'b0;
    logic       btnR = 1'b0;
    logic       rst_out;
    logic       en_out;
    logic [1:0] btn_state;

    board_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .RST_PULSE_CYCLES(P),
        .EN_INIT         (EN_INIT)
    ) dut (
        .clk0     (clk0),
        .rst0     (rst0),
        .btnL     (btnL),
        .btnR     (btnR),
        .rst_out  (rst_out),
        .en_out   (en_out),
        .btn_state(btn_state)
    );

    always #5 clk0 = ~clk0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edge k counts clock edges since reset release.
    // rst_out is high after edge k while k < pulse_end; each accepted btnL
    // press acted on at edge k sets pulse_end = k + P.
    int         k;
    int         pulse_end;
    logic       en_m;
    logic       rst_m;
    logic [1:0] st_m;
    int         last_flip [2];
    bit         raw_h [2][MAXE];
    bit         up_h  [2][MAXE];

    function automatic void model_reset();
        k            = 0;
        pulse_end    = P - 1;
        en_m         = EN_INIT;
        rst_m        = 1'b1;
        st_m         = 2'b00;
        last_flip[0] = -1000;
        last_flip[1] = -1000;
    endfunction

    function automatic void model_step(input logic l, input logic r);
        logic [1:0] in_v;
        bit         ok;
        bit         s2v;
        bit         ev [2];
        bit         hold_before;
        int         idx;
        in_v = {r, l};
        if (k >= MAXE) begin
            $display("FAIL model_range: edge %0d exceeds history %0d", k, MAXE);
            $fatal(1);
        end
        for (int b = 0; b < 2; b++) begin
            raw_h[b][k] = in_v[b];
            // The synchronised sample seen at edge i is the raw input from edge i-2.
            ok = (k - last_flip[b]) >= D;
            for (int j = 0; j < D; j++) begin
                idx = k - j;
                if (idx < 0) begin
                    ok = 1'b0;
                end else begin
                    s2v = (idx >= 2) ? raw_h[b][idx-2] : 1'b0;
                    if (s2v == st_m[b]) ok = 1'b0;
                end
            end
            up_h[b][k] = 1'b0;
            if (ok) begin
                st_m[b]      = ~st_m[b];
                last_flip[b] = k;
                up_h[b][k]   = st_m[b];
            end
            ev[b] = (k >= 2) && up_h[b][k-2];
        end
        hold_before = (k - 1) < pulse_end;
        if (ev[0]) begin
            pulse_end = k + P;
            en_m      = EN_INIT;
        end else if (ev[1] && !hold_before) begin
            en_m = ~en_m;
        end
        rst_m = (k < pulse_end);
        k++;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic l, input logic r);
        @(negedge clk0);
        btnL = l;
        btnR = r;
        @(posedge clk0);
        model_step(l, r);
        #1;
        check("model_rst_out", 32'(rst_out), 32'(rst_m));
        check("model_en_out", 32'(en_out), 32'(en_m));
        check("model_btn_state", 32'(btn_state), 32'(st_m));
    endtask

    task automatic do_reset();
        @(negedge clk0);
        rst0 = 1'b0;
        #1;
        check("reset_rst_out", 32'(rst_out), 32'd1);
        check("reset_en_out", 32'(en_out), 32'(EN_INIT));
        check("reset_btn_state", 32'(btn_state), 32'd0);
        @(posedge clk0);
        #1;
        rst0 = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       l;
        logic       r;
        int         n;
        logic       rs;
        logic       en;
        logic [1:0] bs;
    } vec_t;

    function automatic vec_t v(input logic l, input logic r, input int n,
                               input logic rs, input logic en, input logic [1:0] bs);
        vec_t x;
        x.l  = l;
        x.r  = r;
        x.n  = n;
        x.rs = rs;
        x.en = en;
        x.bs = bs;
        return x;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        logic lv;
        logic rv;
        int   run_l;
        int   run_r;

        // Power-on pulse, then quiet.
        tbl.push_back(v(0, 0, 1, 1, 1, 2'b00));
        tbl.push_back(v(0, 0, 1, 1, 1, 2'b00));
        tbl.push_back(v(0, 0, 1, 0, 1, 2'b00));
        tbl.push_back(v(0, 0, 7, 0, 1, 2'b00));
        // Clean btnL held 20 cycles from edge 10: pulse after edges 17..19 only.
        tbl.push_back(v(1, 0, 5, 0, 1, 2'b00));
        tbl.push_back(v(1, 0, 1, 0, 1, 2'b01));
        tbl.push_back(v(1, 0, 1, 0, 1, 2'b01));
        tbl.push_back(v(1, 0, 1, 1, 1, 2'b01));
        tbl.push_back(v(1, 0, 1, 1, 1, 2'b01));
        tbl.push_back(v(1, 0, 1, 1, 1, 2'b01));
        tbl.push_back(v(1, 0, 1, 0, 1, 2'b01));
        tbl.push_back(v(1, 0, 9, 0, 1, 2'b01));
        tbl.push_back(v(0, 0, 8, 0, 1, 2'b00));
        // Bouncing btnR is never accepted.
        tbl.push_back(v(0, 1, 2, 0, 1, 2'b00));
        tbl.push_back(v(0, 0, 2, 0, 1, 2'b00));
        tbl.push_back(v(0, 1, 2, 0, 1, 2'b00));
        tbl.push_back(v(0, 0, 2, 0, 1, 2'b00));
        tbl.push_back(v(0, 0, 8, 0, 1, 2'b00));
        // Two toggles: en changes 7 cycles after the press is first sampled.
        tbl.push_back(v(0, 1, 5, 0, 1, 2'b00));
        tbl.push_back(v(0, 1, 2, 0, 1, 2'b10));
        tbl.push_back(v(0, 1, 1, 0, 0, 2'b10));
        tbl.push_back(v(0, 1, 4, 0, 0, 2'b10));
        tbl.push_back(v(0, 0, 10, 0, 0, 2'b00));
        tbl.push_back(v(0, 1, 5, 0, 0, 2'b00));
        tbl.push_back(v(0, 1, 2, 0, 0, 2'b10));
        tbl.push_back(v(0, 1, 1, 0, 1, 2'b10));
        tbl.push_back(v(0, 1, 4, 0, 1, 2'b10));
        tbl.push_back(v(0, 0, 10, 0, 1, 2'b00));
        tbl.push_back(v(0, 1, 8, 0, 0, 2'b10));
        tbl.push_back(v(0, 0, 10, 0, 0, 2'b00));
        // Simultaneous press with en=0: btnL wins, en reloads to 1.
        tbl.push_back(v(1, 1, 5, 0, 0, 2'b00));
        tbl.push_back(v(1, 1, 2, 0, 0, 2'b11));
        tbl.push_back(v(1, 1, 1, 1, 1, 2'b11));
        tbl.push_back(v(1, 1, 2, 1, 1, 2'b11));
        tbl.push_back(v(1, 1, 1, 0, 1, 2'b11));
        tbl.push_back(v(0, 0, 10, 0, 1, 2'b00));

        do_reset();
        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++) step(tbl[i].l, tbl[i].r);
            check($sformatf("vec%0d_rst_out", i), 32'(rst_out), 32'(tbl[i].rs));
            check($sformatf("vec%0d_en_out", i), 32'(en_out), 32'(tbl[i].en));
            check($sformatf("vec%0d_btn_state", i), 32'(btn_state), 32'(tbl[i].bs));
        end

        // btnR accepted one edge after btnL: its event lands inside the pulse and is dropped.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, (i >= 1));
            if (i == 7) check("late_r_pulse_start", 32'(rst_out), 32'd1);
            if (i == 8) check("late_r_en_kept", 32'(en_out), 32'd1);
            if (i == 10) check("late_r_pulse_end", 32'(rst_out), 32'd0);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        check("late_r_not_queued", 32'(en_out), 32'd1);

        // Mid-operation reset in the second HOLD cycle, after en was cleared.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        check("midrst_en_cleared", 32'(en_out), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        check("midrst_in_hold", 32'(rst_out), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("midrst_pulse%0d", i), 32'(rst_out), (i < 2) ? 32'd1 : 32'd0);
        end

        // Random button activity with occasional asynchronous resets.
        lv    = 1'b0;
        rv    = 1'b0;
        run_l = 0;
        run_r = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_l == 0) begin
                lv    = 1'($urandom_range(0, 1));
                run_l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14)) : int'($urandom_range(1, 4));
            end
            if (run_r == 0) begin
                rv    = 1'($urandom_range(0, 1));
                run_r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 14)) : int'($urandom_range(1, 4));
            end
            run_l--;
            run_r--;
            if ($urandom_range(0, 399) == 0) do_reset();
            step(lv, rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
